morse_letter_queue: RTL and testbench
=====================================

MORSE_LETTER_QUEUE -- requirements
Module: morse_letter_queue

Interface
REQ-001 Parameter MAX_SYMS, default 6, maximum symbols per letter; legal range 1..16.
REQ-002 Parameter DEPTH, default 8, letter FIFO depth; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 new_dot  input  1  one-cycle pulse that appends a dot.
REQ-006 new_dash  input  1  one-cycle pulse that appends a dash.
REQ-007 undo  input  1  removes the most recent symbol of the letter under assembly.
REQ-008 clear  input  1  discards the letter under assembly.
REQ-009 commit  input  1  end-of-letter; pushes the assembled letter into the FIFO.
REQ-010 flush  input  1  empties the FIFO.
REQ-011 err_clr  input  1  clears sticky error flags.
REQ-012 cur_data  output  2*MAX_SYMS  letter under assembly, right-aligned.
REQ-013 cur_count  output  clog2(MAX_SYMS+1)  number of symbols in cur_data.
REQ-014 out_valid  output  1  FIFO head is valid.
REQ-015 out_ready  input  1  consumer accepts the head when out_valid is high.
REQ-016 out_data  output  2*MAX_SYMS  head letter pattern.
REQ-017 out_count  output  clog2(MAX_SYMS+1)  head letter symbol count.
REQ-018 level  output  clog2(DEPTH+1)  number of letters in the FIFO.
REQ-019 sym_ovf  output  1  sticky flag: a symbol was refused because the letter was full.
REQ-020 drop_err  output  1  sticky flag: a letter was lost because the FIFO was full.

Function
REQ-021 Symbol encoding: dot 2'b01, dash 2'b10; the oldest symbol sits at the most significant occupied position, and the newest enters at bits [1:0] by left shift.
REQ-022 Assembly priority per cycle: clear, then undo, then new_dot, then new_dash; dot wins when dot and dash coincide.
REQ-023 Append: when cur_count < MAX_SYMS, shift left by 2, insert the code and increment cur_count in the next cycle.
REQ-024 Append at cur_count == MAX_SYMS: symbol ignored, cur_data and cur_count unchanged, sym_ovf set.
REQ-025 Undo: when cur_count > 0, shift right by 2 and decrement cur_count; when cur_count == 0, no effect and no flag.
REQ-026 Commit with cur_count > 0: push the pre-cycle {cur_data, cur_count} and zero the assembly; a same-cycle dot or dash becomes symbol 1 of the new letter.
REQ-027 Commit with cur_count == 0: no push, no flag.
REQ-028 Commit together with clear or undo: clear and undo are ignored, and the commit behaves as in REQ-026.
REQ-029 FIFO is first-word-fall-through: out_valid = (level != 0), and out_data/out_count show the head combinationally from storage.
REQ-030 Pop occurs when out_valid && out_ready; out_data/out_count are ignored by consumers when out_valid is low, and are held at the last head value.
REQ-031 Latency: a commit in cycle N into an empty FIFO gives out_valid high in cycle N+1.
REQ-032 Push while full without a same-cycle pop: the letter is dropped, drop_err is set, the assembly is still zeroed, and the FIFO is unchanged.
REQ-033 Push while full with a same-cycle pop: both succeed and level stays at DEPTH.
REQ-034 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; level never exceeds DEPTH and never underflows.
REQ-035 Flush sets level and both pointers to 0 next cycle, overrides push and pop in the same cycle, and leaves the assembly untouched.
REQ-036 err_clr clears sym_ovf and drop_err; a same-cycle set event wins.

Reset
REQ-037 While rst_n is low: cur_data, cur_count, level, both pointers, sym_ovf and drop_err are 0, and out_valid is 0.
REQ-038 FIFO storage is not reset.
REQ-039 Reset asserted mid-letter or mid-transfer discards all content immediately, without waiting for a clock edge.

Structure
REQ-040 Shared package morse_pkg holds SYM_W = 2, SYM_DOT, SYM_DASH and the function that computes the count width.
REQ-041 Storage and pointers are in sub-module morse_letter_fifo, parametrised by DATA_W and DEPTH; assembly logic and flags stay in the top level.

Verification
REQ-042 dot, dash, dot, commit, out_ready held high -> out_valid for 1 cycle with out_data[5:0] = 6'b011001 and out_count = 3.
REQ-043 Seven dots, MAX_SYMS = 6 -> cur_count = 6, cur_data = 12'h555 and sym_ovf = 1; then err_clr -> sym_ovf = 0.
REQ-044 dash, dash, undo, dot, commit -> head out_data[3:0] = 4'b1001 and out_count = 2.
REQ-045 Nine single-dot commits, DEPTH = 8, out_ready = 0 -> level = 8 and drop_err = 1; draining yields 8 letters each with out_count = 1.
REQ-046 FIFO full, commit and pop in the same cycle -> level stays 8 and drop_err stays 0; flush then gives level = 0 and out_valid = 0 the next cycle.
REQ-047 commit plus dash in the same cycle after dot, dot -> pushed letter is 4'b0101 with count 2, and cur_data = 2'b10 with cur_count = 1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter queue.
// Holds the symbol width, the dot/dash codes and the helper that sizes
// symbol-count fields so every file agrees on the letter layout.
package morse_pkg;

  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] SYM_DOT  = 2'b01;
  localparam logic [SYM_W-1:0] SYM_DASH = 2'b10;

  // Width of a field that must hold any value 0..max_syms inclusive.
  function automatic int count_w(input int max_syms);
    return $clog2(max_syms + 1);
  endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// First-word-fall-through FIFO of assembled letters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : write request / read request (pop ignored when empty)
//   flush      : empties the FIFO, overriding push and pop
//   wdata      : letter written on push
//   rdata      : head letter (held at the last head while empty)
//   level      : number of stored letters
//   drop       : push refused this cycle because the FIFO is full
module morse_letter_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [LW-1:0]     level_nxt_s;
  logic [DATA_W-1:0] last_head_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  assign full_s  = (level_r == LW'(DEPTH));
  assign empty_s = (level_r == {LW{1'b0}});
  assign pop_s   = pop && !empty_s;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s  = push && (!full_s || pop_s);
  assign drop    = push && full_s && !pop_s;

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointer and occupancy registers; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      level_r <= level_nxt_s;
    end
  end

  // Letter storage; deliberately left without reset.
  always_ff @(posedge clk) begin
    if (push_s && !flush) mem_r[wr_ptr_r] <= wdata;
  end

  // Remembers the head shown while non-empty so rdata does not expose stale slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_head_r <= {DATA_W{1'b0}};
    end else if (!empty_s) begin
      last_head_r <= mem_r[rd_ptr_r];
    end
  end

  assign rdata = empty_s ? last_head_r : mem_r[rd_ptr_r];
  assign level = level_r;

endmodule

// File: rtl/morse_letter_queue.sv
// Morse letter assembler feeding a FIFO of completed letters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   new_dot, new_dash   : append a symbol to the letter under assembly
//   undo, clear         : drop newest symbol / whole letter under assembly
//   commit              : push the assembled letter into the FIFO
//   flush, err_clr      : empty the FIFO / clear sticky error flags
//   cur_data, cur_count : letter under assembly (right-aligned) and its length
//   out_valid/out_ready : FIFO head handshake, out_data/out_count the head
//   level               : letters held in the FIFO
//   sym_ovf, drop_err   : sticky overflow flags (letter full / FIFO full)
module morse_letter_queue
  import morse_pkg::*;
#(
  parameter int MAX_SYMS = 6,
  parameter int DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          new_dot,
  input  logic                          new_dash,
  input  logic                          undo,
  input  logic                          clear,
  input  logic                          commit,
  input  logic                          flush,
  input  logic                          err_clr,
  output logic [2*MAX_SYMS-1:0]         cur_data,
  output logic [count_w(MAX_SYMS)-1:0]  cur_count,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*MAX_SYMS-1:0]         out_data,
  output logic [count_w(MAX_SYMS)-1:0]  out_count,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          sym_ovf,
  output logic                          drop_err
);

  localparam int DW = SYM_W * MAX_SYMS;
  localparam int CW = count_w(MAX_SYMS);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DW-1:0]    cur_data_r;
  logic [CW-1:0]    cur_count_r;
  logic [DW-1:0]    data_nxt_s;
  logic [CW-1:0]    count_nxt_s;
  logic [SYM_W-1:0] sym_code_s;
  logic             sym_req_s;
  logic             ovf_set_s;
  logic             push_s;
  logic             drop_s;
  logic             sym_ovf_r;
  logic             drop_err_r;
  logic [LW-1:0]    level_s;
  logic [DW+CW-1:0] rdata_s;

  assign sym_req_s  = new_dot || new_dash;
  assign sym_code_s = new_dot ? SYM_DOT : SYM_DASH;
  assign push_s     = commit && (cur_count_r != {CW{1'b0}});

  // Next letter under assembly: commit, clear, undo, then append.
  always_comb begin
    data_nxt_s  = cur_data_r;
    count_nxt_s = cur_count_r;
    ovf_set_s   = 1'b0;
    if (commit) begin
      // Commit ignores clear/undo; a same-cycle symbol starts the next letter.
      if (sym_req_s) begin
        data_nxt_s  = DW'(sym_code_s);
        count_nxt_s = CW'(1);
      end else begin
        data_nxt_s  = {DW{1'b0}};
        count_nxt_s = {CW{1'b0}};
      end
    end else if (clear) begin
      data_nxt_s  = {DW{1'b0}};
      count_nxt_s = {CW{1'b0}};
    end else if (undo) begin
      if (cur_count_r != {CW{1'b0}}) begin
        data_nxt_s  = cur_data_r >> SYM_W;
        count_nxt_s = cur_count_r - CW'(1);
      end else begin
        data_nxt_s  = cur_data_r;
        count_nxt_s = cur_count_r;
      end
    end else if (sym_req_s) begin
      if (cur_count_r < CW'(MAX_SYMS)) begin
        data_nxt_s  = (cur_data_r << SYM_W) | DW'(sym_code_s);
        count_nxt_s = cur_count_r + CW'(1);
      end else begin
        ovf_set_s   = 1'b1;
      end
    end else begin
      data_nxt_s  = cur_data_r;
      count_nxt_s = cur_count_r;
    end
  end

  // Assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_data_r  <= {DW{1'b0}};
      cur_count_r <= {CW{1'b0}};
    end else begin
      cur_data_r  <= data_nxt_s;
      cur_count_r <= count_nxt_s;
    end
  end

  // Sticky flags; a set event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_ovf_r  <= 1'b0;
      drop_err_r <= 1'b0;
    end else begin
      if (ovf_set_s)    sym_ovf_r <= 1'b1;
      else if (err_clr) sym_ovf_r <= 1'b0;
      if (drop_s)       drop_err_r <= 1'b1;
      else if (err_clr) drop_err_r <= 1'b0;
    end
  end

  morse_letter_fifo #(
    .DATA_W (DW + CW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (out_ready),
    .flush (flush),
    .wdata ({cur_data_r, cur_count_r}),
    .rdata (rdata_s),
    .level (level_s),
    .drop  (drop_s)
  );

  assign {out_data, out_count} = rdata_s;
  assign out_valid = (level_s != {LW{1'b0}});
  assign level     = level_s;
  assign cur_data  = cur_data_r;
  assign cur_count = cur_count_r;
  assign sym_ovf   = sym_ovf_r;
  assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_morse_letter_queue.sv
// Self-checking bench for morse_letter_queue: a symbol-list reference model
// predicts every letter; a separate monitor pops the expected queue whenever
// the DUT hands over a head letter.
module tb_morse_letter_queue;

  localparam int MAX_SYMS = 6;
  localparam int DEPTH    = 8;

  // Stimulus vector bits: {dot, dash, undo, clear, commit, flush, err_clr, ready}
  localparam logic [7:0] D = 8'h80, H = 8'h40, U = 8'h20, C = 8'h10;
  localparam logic [7:0] M = 8'h08, F = 8'h04, E = 8'h02, R = 8'h01;

  typedef struct { int data; int cnt; } letter_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_dot = 1'b0, new_dash = 1'b0, undo = 1'b0, clear = 1'b0;
  logic        commit = 1'b0, flush = 1'b0, err_clr = 1'b0, out_ready = 1'b0;
  logic [11:0] cur_data, out_data;
  logic [2:0]  cur_count, out_count;
  logic [3:0]  level;
  logic        out_valid, sym_ovf, drop_err;

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;

  // Reference model state.
  int      cur_q[$];
  letter_t model_q[$];
  letter_t exp_q[$];
  bit      m_ovf = 1'b0;
  bit      m_drop = 1'b0;

  morse_letter_queue #(.MAX_SYMS(MAX_SYMS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .new_dot(new_dot), .new_dash(new_dash),
    .undo(undo), .clear(clear), .commit(commit), .flush(flush),
    .err_clr(err_clr), .cur_data(cur_data), .cur_count(cur_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .level(level), .sym_ovf(sym_ovf), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Letter value: symbols oldest-first, each a base-4 digit (dot 1, dash 2).
  function automatic int enc(input int q[$]);
    int d = 0;
    foreach (q[i]) d = d * 4 + q[i];
    return d;
  endfunction

  task automatic check_state();
    chk("cur_data", int'(cur_data), enc(cur_q));
    chk("cur_count", int'(cur_count), cur_q.size());
    chk("level", int'(level), model_q.size());
    chk("out_valid", int'(out_valid), int'(model_q.size() != 0));
    chk("sym_ovf", int'(sym_ovf), int'(m_ovf));
    chk("drop_err", int'(drop_err), int'(m_drop));
  endtask

  // Apply the specification's rules for one clock edge.
  task automatic model_step();
    bit sym = new_dot || new_dash;
    int code = new_dot ? 1 : 2;
    bit pop = out_ready && (model_q.size() != 0);
    bit push = commit && (cur_q.size() > 0);
    bit full = (model_q.size() == DEPTH);
    bit ovf = 1'b0;
    bit drop = push && full && !pop;
    letter_t l;
    l.data = enc(cur_q);
    l.cnt = cur_q.size();
    if (commit) begin
      cur_q.delete();
      if (sym) cur_q.push_back(code);
    end else if (clear) begin
      cur_q.delete();
    end else if (undo) begin
      if (cur_q.size() > 0) void'(cur_q.pop_back());
    end else if (sym) begin
      if (cur_q.size() < MAX_SYMS) cur_q.push_back(code);
      else ovf = 1'b1;
    end
    if (flush) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push && !drop) begin
        model_q.push_back(l);
        exp_q.push_back(l);
      end
    end
    if (ovf) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
    if (drop) m_drop = 1'b1; else if (err_clr) m_drop = 1'b0;
  endtask

  // Called at posedge+1: drive, check state mid-cycle, step the model at the edge.
  task automatic drive(input logic [7:0] v);
    {new_dot, new_dash, undo, clear, commit, flush, err_clr, out_ready} = v;
    @(negedge clk);
    check_state();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: every accepted head letter must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        letter_t e;
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_count", int'(out_count), e.cnt);
        pop_cnt++;
      end
    end
  end

  initial begin
    int p0;
    logic [7:0] v;
    #12;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_cur_count", int'(cur_count), 0);
    chk("rst_cur_data", int'(cur_data), 0);
    chk("rst_flags", int'({sym_ovf, drop_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // dot dash dot, commit with ready held: head visible for exactly one cycle
    drive(D); drive(H); drive(D); drive(M | R);
    chk("l1_valid", int'(out_valid), 1);
    chk("l1_data", int'(out_data), 12'h019);
    chk("l1_count", int'(out_count), 3);
    drive(R);
    chk("l1_valid_gone", int'(out_valid), 0);

    // seven dots overflow the letter, then err_clr
    for (int i = 0; i < 7; i++) drive(D);
    chk("ovf_count", int'(cur_count), 6);
    chk("ovf_data", int'(cur_data), 12'h555);
    chk("ovf_flag", int'(sym_ovf), 1);
    drive(E);
    chk("ovf_cleared", int'(sym_ovf), 0);
    drive(C);

    // dash dash undo dot commit
    drive(H); drive(H); drive(U); drive(D); drive(M);
    chk("undo_data", int'(out_data), 12'h009);
    chk("undo_count", int'(out_count), 2);
    drive(R);

    // dot dot, commit plus dash
    drive(D); drive(D); drive(M | H);
    chk("cd_cur_data", int'(cur_data), 2);
    chk("cd_cur_count", int'(cur_count), 1);
    chk("cd_out_data", int'(out_data), 12'h005);
    chk("cd_out_count", int'(out_count), 2);
    drive(C | R);

    // nine single-dot letters into an eight-deep FIFO
    drive(E);
    for (int i = 0; i < 9; i++) begin drive(D); drive(M); end
    chk("fill_level", int'(level), 8);
    chk("fill_drop", int'(drop_err), 1);
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) drive(R);
    chk("drain_pops", pop_cnt - p0, 8);
    chk("drain_level", int'(level), 0);

    // full FIFO with simultaneous push and pop, then flush
    drive(E);
    for (int i = 0; i < 8; i++) begin drive(D); drive(M); end
    drive(D); drive(M | R);
    chk("fullpp_level", int'(level), 8);
    chk("fullpp_drop", int'(drop_err), 0);
    drive(F);
    chk("flush_level", int'(level), 0);
    chk("flush_valid", int'(out_valid), 0);

    // asynchronous reset mid-letter with letters queued
    drive(D); drive(M); drive(H);
    {new_dot, new_dash, undo, clear, commit, flush, err_clr, out_ready} = 8'h00;
    rst_n = 1'b0;
    #2;
    chk("arst_cur_count", int'(cur_count), 0);
    chk("arst_cur_data", int'(cur_data), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_valid", int'(out_valid), 0);
    cur_q.delete(); model_q.delete(); exp_q.delete();
    m_ovf = 1'b0; m_drop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = 8'h00;
      if ($urandom_range(0, 99) < 30) v |= D;
      if ($urandom_range(0, 99) < 25) v |= H;
      if ($urandom_range(0, 99) < 8)  v |= U;
      if ($urandom_range(0, 99) < 3)  v |= C;
      if ($urandom_range(0, 99) < 15) v |= M;
      if ($urandom_range(0, 99) < 2)  v |= F;
      if ($urandom_range(0, 99) < 5)  v |= E;
      if ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 15)) v |= R;
      drive(v);
    end
    drive(8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
